phase_sequencer: RTL

Run-control sequencer for the 16-bit multi-cycle core. It turns the debounced EXEC push-button into a run/pause/single-step state machine. It generates the one-hot phase signals (p0…p4) and the `exec` level consumed by the control decoder, and it retires instructions. It enters a terminal halt state when the decoder raises `stop_flag`.

---
 rtl/phase_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Run-control sequencer: debounces the EXEC button and drives the run/pause/step/halt
// state machine, the one-hot phase vector, exec level and the retired-instruction count.
module phase_sequencer #(
  parameter int NUM_PHASES      = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exec_btn,
  input  logic                  step_mode,
  input  logic                  stop_flag,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  p0,
  output logic                  exec,
  output logic                  running,
  output logic                  halted,
  output logic                  press,
  output logic [15:0]           retired
);

  localparam logic [15:0]           DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_PHASES-1:0] FIRST   = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  logic        sync1, sync2, db;
  logic [15:0] db_cnt;

  state_t                  state, state_n;
  logic [NUM_PHASES-1:0]   phase_n;
  logic                    pause_pending, pause_n;
  logic                    stop_pending, stop_n;
  logic [15:0]             retired_n;

  // press is raised on the same edge db rises so it stays a registered output
  // without costing an extra cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= exec_btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync2;
        db_cnt <= '0;
        press  <= sync2;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    pause_n   = pause_pending;
    stop_n    = stop_pending;
    retired_n = retired;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = RUN;
          phase_n = FIRST;
          pause_n = step_mode;
          stop_n  = 1'b0;
        end
      end
      RUN: begin
        if (phase[NUM_PHASES-1]) begin
          // instruction boundary: retire, then halt beats pause beats continue
          retired_n = retired + 16'd1;
          pause_n   = 1'b0;
          stop_n    = 1'b0;
          if (stop_pending || stop_flag) begin
            state_n = HALT;
            phase_n = '0;
          end else if (pause_pending || press) begin
            state_n = IDLE;
            phase_n = '0;
          end else begin
            phase_n = FIRST;
          end
        end else begin
          phase_n = {phase[NUM_PHASES-2:0], 1'b0};
          pause_n = pause_pending | press | step_mode;
          stop_n  = stop_pending | stop_flag;
        end
      end
      HALT: begin
        phase_n = '0;
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      pause_pending <= 1'b0;
      stop_pending  <= 1'b0;
      retired       <= '0;
      exec          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      pause_pending <= pause_n;
      stop_pending  <= stop_n;
      retired       <= retired_n;
      exec          <= (state_n == RUN);
      halted        <= (state_n == HALT);
    end
  end

  assign p0      = phase[0];
  assign running = exec;

endmodule
